// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU decode, the DMA/debug loader and the shared data RAM.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface ram_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 4
);
  logic          cpu_cs;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [3:0]    dma_len;
  logic [DW-1:0] dma_wdata;
  logic          dma_wnext;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          dma_busy;
  logic          dma_done;

  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_wnext, dma_rdata, dma_rvalid, dma_busy, dma_done,
    output ram_cs, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_wnext, dma_rdata, dma_rvalid, dma_busy, dma_done,
    input  ram_cs, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter: zero-latency CPU pass-through in IDLE, uninterrupted
// DMA bursts of 1-16 nibbles, and a starvation counter that lets DMA beat a busy CPU.
module ram_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int          SW         = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  logic [1:0]    state_reg, state_next;
  logic [3:0]    beat_reg, beat_next;
  logic [3:0]    len_reg, len_next;
  logic [AW-1:0] base_reg, base_next;
  logic          we_reg, we_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          rvalid_reg, rvalid_next;
  logic          dma_win;

  assign dma_win = (state_reg == ST_IDLE) && bus.dma_req &&
                   (!bus.cpu_cs || (starve_reg == STARVE_MAX));

  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.dma_rdata  = rdata_reg;
  assign bus.dma_rvalid = rvalid_reg;
  assign bus.dma_busy   = (state_reg == ST_BURST) || (state_reg == ST_DONE);
  assign bus.dma_done   = (state_reg == ST_DONE);

  always_comb begin
    bus.ram_cs    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.cpu_stall = 1'b0;
    bus.dma_wnext = 1'b0;
    state_next    = state_reg;
    beat_next     = beat_reg;
    len_next      = len_reg;
    base_next     = base_reg;
    we_next       = we_reg;
    starve_next   = starve_reg;
    rdata_next    = rdata_reg;
    rvalid_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (dma_win) begin
          bus.cpu_stall = bus.cpu_cs;
          state_next    = ST_BURST;
          base_next     = bus.dma_addr;
          len_next      = bus.dma_len;
          we_next       = bus.dma_we;
          beat_next     = 4'd0;
          starve_next   = '0;
        end else begin
          bus.ram_cs = bus.cpu_cs;
          bus.ram_we = bus.cpu_cs & bus.cpu_we;
          if (bus.cpu_cs && bus.dma_req) begin
            starve_next = (starve_reg == STARVE_MAX) ? STARVE_MAX : starve_reg + 1'b1;
          end else if (!bus.dma_req) begin
            starve_next = '0;
          end
        end
      end
      ST_BURST: begin
        bus.cpu_stall = bus.cpu_cs;
        bus.ram_cs    = 1'b1;
        bus.ram_we    = we_reg;
        // Address arithmetic wraps at the top of the AW-bit space.
        bus.ram_addr  = base_reg + AW'(beat_reg);
        bus.ram_wdata = bus.dma_wdata;
        bus.dma_wnext = we_reg;
        rvalid_next   = ~we_reg;
        if (!we_reg) rdata_next = bus.ram_rdata;
        beat_next     = beat_reg + 4'd1;
        if (beat_reg == len_reg) begin
          state_next = ST_DONE;
          beat_next  = 4'd0;
        end
      end
      ST_DONE: begin
        bus.cpu_stall = bus.cpu_cs;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      beat_reg   <= 4'd0;
      len_reg    <= 4'd0;
      base_reg   <= '0;
      we_reg     <= 1'b0;
      starve_reg <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      beat_reg   <= beat_next;
      len_reg    <= len_next;
      base_reg   <= base_next;
      we_reg     <= we_next;
      starve_reg <= starve_next;
      rdata_reg  <= rdata_next;
      rvalid_reg <= rvalid_next;
    end
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port 4096×4 data RAM between the uP core and a DMA/debug loader port. The CPU gets single-cycle pass-through accesses. The DMA port gets uninterrupted bursts of 1–16 nibbles. A starvation counter guarantees DMA progress against a CPU that accesses RAM every cycle. The block sits between the core's RAM control decode (cs/we/address) and the RAM; tri-state bus drivers stay at top level.

## Interface
Parameters:
- AW, 12, address width (matches 12-bit PC/RAM address space)
- DW, 4, data nibble width
- STARVE_LIM, 4, consecutive lost IDLE cycles after which a pending DMA request beats the CPU

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_cs  in  1  CPU RAM access request (combinational from decode)
- cpu_we  in  1  CPU write when 1, read when 0
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, combinational from ram_rdata
- cpu_stall  out  1  CPU access not performed this cycle; core must hold phase/PC
- dma_req  in  1  DMA burst request, level; held until dma_done
- dma_we  in  1  burst direction, sampled at grant
- dma_addr  in  AW  burst base address, sampled at grant
- dma_len  in  4  beats minus one (0 = 1 beat, 15 = 16 beats), sampled at grant
- dma_wdata  in  DW  write data for current beat
- dma_wnext  out  1  write beat consumed this cycle; source advances to next nibble
- dma_rdata  out  DW  registered read data
- dma_rvalid  out  1  dma_rdata valid this cycle
- dma_busy  out  1  high in BURST and DONE
- dma_done  out  1  one-cycle pulse at burst end
- ram_cs, ram_we  out  1 each  RAM controls
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data (combinational read)

## Operation
- States: IDLE, BURST, DONE.
- Win condition in IDLE: `dma_win = dma_req & (~cpu_cs | starve_cnt == STARVE_LIM)`.
- IDLE, `cpu_cs & ~dma_win`:
  - ram_* = cpu_* combinationally; cpu_stall=0.
  - If dma_req is also high, starve_cnt increments, saturating at STARVE_LIM.
- IDLE, dma_win:
  - No RAM access this cycle; cpu_stall=cpu_cs.
  - At the edge: latch base/len/we, beat=0, starve_cnt=0, go to BURST.
- IDLE, `~dma_req`: starve_cnt=0.
- BURST:
  - ram_cs=1, ram_addr = base + beat, modulo 2^AW (0xFFF wraps to 0x000), ram_we = we_r, ram_wdata = dma_wdata.
  - Writes: dma_wnext=1 every BURST cycle.
  - Reads: ram_rdata is registered into dma_rdata, with dma_rvalid=1 on the following cycle.
  - beat increments; when beat==len, go to DONE at the edge.
  - cpu_stall = cpu_cs.
- DONE:
  - No RAM access; dma_done=1; last read beat's dma_rvalid appears here.
  - cpu_stall = cpu_cs; return to IDLE.
- dma_req deasserted mid-burst is ignored; the burst completes.
- dma_req still high in the IDLE cycle after DONE is a new request.
- ram_cs=0, ram_we=0 whenever no access is granted; ram_we is never 1 with ram_cs 0.

## Timing
- Reset values: state IDLE, beat 0, starve_cnt 0, dma_rdata 0, dma_rvalid/dma_done/dma_busy/dma_wnext 0. ram_cs/ram_we 0 unless an IDLE CPU pass-through is active. cpu_stall 0.
- CPU path: zero latency, fully combinational in IDLE.
- DMA grant: req sampled at edge k → BURST cycles k+1 … k+1+len → DONE at k+2+len → IDLE at k+3+len.
  - N-beat burst occupies N+1 cycles after grant, plus the grant cycle in IDLE.
- Read data: beat i address in cycle k+1+i; dma_rvalid with that data in cycle k+2+i.
- Reset mid-burst: back to IDLE next edge with outputs as listed; no dma_done; the partial burst is lost.
- Simultaneous cpu_cs and dma_req with starve_cnt<STARVE_LIM: CPU wins.
- Simultaneous cpu_cs and dma_req with starve_cnt==STARVE_LIM: DMA wins and CPU stalls.

## Test plan
- CPU only:
  - Write 0xA at 0x123, next cycle read 0x123 → cpu_rdata=0xA, cpu_stall=0 throughout.
  - ram_* mirrors cpu_* the same cycle.
- DMA write burst, idle CPU:
  - base 0x010, len 3, data 1,2,3,4 → dma_wnext high 4 cycles.
  - RAM 0x010–0x013 = 1,2,3,4.
  - dma_done 5 cycles after grant edge; dma_busy high 5 cycles.
- DMA read burst wrap:
  - base 0xFFE, len 3 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
  - 4 dma_rvalid pulses with the stored nibbles, in order.
- Starvation:
  - cpu_cs=1 every cycle with dma_req raised → CPU serviced exactly 4 cycles.
  - DMA granted on the 5th; cpu_stall=1 for grant+BURST+DONE.
- Collision under burst:
  - cpu_cs during BURST → cpu_stall=1, no CPU write reaches RAM (target address unchanged).
  - CPU proceeds in the first IDLE cycle.
- Reset mid-burst:
  - Assert reset at beat 2 of an 8-beat write → next cycle IDLE, dma_busy=0, no dma_done.
  - Only beats 0–2 written.
